axi_lite_reg_bank: RTL and testbench
====================================

// Module: axi_lite_reg_bank
// PURPOSE
//   Parametrised AXI4-Lite slave exposing NUM_REGS word-wide control/status registers.
//   Successor to the single-block AXI-lite register slave, with these additions:
//     - configurable register count;
//     - per-register read-only mask (RO registers read fabric inputs);
//     - WSTRB byte-lane writes and independent AW/W acceptance;
//     - SLVERR on bad accesses.
//   Sits between the AXI-lite interconnect and fabric logic.
// PARAMETERS
//   DATA_WIDTH  32            data bus width; multiple of 8
//   ADDR_WIDTH  32            AXI address width
//   NUM_REGS    8             number of registers; >=1
//   RO_MASK     {NUM_REGS{0}} bit i=1 -> reg i read-only, reads reg_in[i]
//   RESET_VAL   0             reset value of every RW register
// PORTS
//   clk            in   1                     clock; all logic on rising edge
//   rst            in   1                     synchronous, active-high reset
//   S_AXI_AWADDR   in   ADDR_WIDTH            write address
//   S_AXI_AWVALID  in   1                     write address valid
//   S_AXI_AWREADY  out  1                     write address ready
//   S_AXI_WDATA    in   DATA_WIDTH            write data
//   S_AXI_WSTRB    in   DATA_WIDTH/8          byte-lane enables
//   S_AXI_WVALID   in   1                     write data valid
//   S_AXI_WREADY   out  1                     write data ready
//   S_AXI_BRESP    out  2                     write response
//   S_AXI_BVALID   out  1                     write response valid
//   S_AXI_BREADY   in   1                     write response ready
//   S_AXI_ARADDR   in   ADDR_WIDTH            read address
//   S_AXI_ARVALID  in   1                     read address valid
//   S_AXI_ARREADY  out  1                     read address ready
//   S_AXI_RDATA    out  DATA_WIDTH            read data
//   S_AXI_RRESP    out  2                     read response
//   S_AXI_RVALID   out  1                     read data valid
//   S_AXI_RREADY   in   1                     read data ready
//   reg_out        out  NUM_REGS*DATA_WIDTH   RW register contents; reg i at [i*DW +: DW]
//   reg_in         in   NUM_REGS*DATA_WIDTH   status inputs, read back for RO registers
//   wr_pulse       out  NUM_REGS              optional, see CONFIGURATION
// BEHAVIOUR
//   Reset: BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0, AW/W holding slots empty,
//     AWREADY=WREADY=ARREADY=1, RW regs=RESET_VAL. Outstanding transactions are dropped.
//   Address decode: ADDR_LSB=log2(DATA_WIDTH/8).
//     idx = ADDR[ADDR_LSB +: clog2(NUM_REGS)]; low ADDR_LSB bits are ignored.
//     Out of range when idx>=NUM_REGS or any higher address bit is set.
//   Write path:
//     - AW and W are each captured into a one-entry slot.
//     - AWREADY = !aw_full; WREADY = !w_full. Either channel may arrive first or both together.
//     - Write commits on the edge where both slots are full (or being filled) and (!BVALID | BREADY).
//       That edge: update reg, free both slots, set BVALID=1. Minimum AW/W->BVALID latency is 1 clk.
//     - Per-lane update: byte b written only where WSTRB[b]=1. WSTRB=0 is a legal no-op with OKAY.
//     - Out-of-range or RO target: no register change, BRESP=2'b10 (SLVERR). Otherwise BRESP=2'b00.
//     - BVALID holds with a stable BRESP until BREADY. Back-to-back writes at one per clk when BREADY=1.
//   Read path:
//     - ARREADY = !RVALID | RREADY.
//     - On AR handshake, RDATA/RRESP are registered next edge and RVALID=1.
//       RDATA is the register for RW, reg_in slice for RO, 0 with RRESP=2'b10 for out of range.
//     - RDATA/RRESP are held stable until RREADY. One read per clk when RREADY=1.
//   Simultaneous read and write to the same register on one edge: read returns the pre-write value.
//   Read and write channels are fully independent; no ordering between them.
// CONFIGURATION
//   AXIL_REG_WR_PULSE_EN defined:
//     - wr_pulse[i]=1 for exactly one clk, on the edge after a commit to RW reg i with OKAY.
//       Asserted even when WSTRB=0.
//     - No pulse on SLVERR. Reset value 0.
//   AXIL_REG_WR_PULSE_EN undefined: wr_pulse is tied to 0 and no pulse logic is built.
// TESTING
//   1. After reset, read 0x0..0x1C (NUM_REGS=8) -> RDATA=RESET_VAL, RRESP=0; ARREADY/AWREADY/WREADY=1.
//   2. W 0xDEADBEEF sent 3 clk before AW 0x4 -> BVALID 1 clk after AW handshake, BRESP=0.
//      Read 0x4 -> 0xDEADBEEF; reg_out[63:32]=0xDEADBEEF.
//   3. Reg 2 = 0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 -> read 0x8 = 0x11BB33DD.
//   4. RO_MASK=8'h80, reg_in[255:224]=0xCAFE0001. Write 0x1C -> BRESP=2'b10, reg unchanged.
//      Read 0x1C -> 0xCAFE0001. Read 0x20 -> RDATA=0, RRESP=2'b10.
//   5. Hold BREADY/RREADY=0 for 5 clk with a new AW/W/AR pending:
//      - BVALID/RVALID and their data stay stable; ARREADY=0.
//      - Only one AW/W pair is absorbed; it commits on the BREADY edge.
//   6. Assert rst mid-write (AW held, W not yet sent) -> next clk all VALIDs=0, slots empty.
//      Regs=RESET_VAL; no stale commit follows when W arrives.
//      With AXIL_REG_WR_PULSE_EN: write to 0x0 -> wr_pulse=8'h01 for exactly 1 clk.

Source files
------------

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle for axi_lite_reg_bank: master drives requests, slave drives responses.
// A beat transfers on a rising edge where VALID and READY are both 1; VALID never waits on READY,
// and once raised VALID and its payload stay stable until that transfer edge.
interface axi_lite_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave with NUM_REGS word registers, read-only mask, WSTRB lane writes and SLVERR.
// Optional macro AXIL_REG_WR_PULSE_EN adds a one-clock wr_pulse per successful register write.
module axi_lite_reg_bank #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_reg_bank_if.slave             s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_L  = (IDX_W+1)'(NUM_REGS);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_reg_in [NUM_REGS];

  logic                  r_aw_full, r_w_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_aw_addr, w_aw_sh, w_ar_sh;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_aw_idx, w_ar_idx;
  logic                  w_aw_in_range, w_ar_in_range, w_wr_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_map
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      assign w_reg_in[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign s_axi.awready = !r_aw_full;
  assign s_axi.wready  = !r_w_full;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = !r_rvalid || s_axi.rready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;

  assign w_aw_hs = s_axi.awvalid && !r_aw_full;
  assign w_w_hs  = s_axi.wvalid && !r_w_full;
  assign w_ar_hs = s_axi.arvalid && s_axi.arready;

  // A slot counts as available on the same edge it is being filled, giving 1-clk write latency.
  assign w_aw_addr = r_aw_full ? r_aw_addr : s_axi.awaddr;
  assign w_wdata   = r_w_full  ? r_wdata   : s_axi.wdata;
  assign w_wstrb   = r_w_full  ? r_wstrb   : s_axi.wstrb;
  assign w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && (!r_bvalid || s_axi.bready);

  assign w_aw_sh       = w_aw_addr >> ADDR_LSB;
  assign w_aw_idx      = w_aw_sh[IDX_W-1:0];
  assign w_aw_in_range = ((w_aw_sh >> IDX_W) == '0) && ({1'b0, w_aw_idx} < NUM_REGS_L);
  assign w_wr_ok       = w_aw_in_range && !RO_MASK[w_aw_idx];

  assign w_ar_sh       = s_axi.araddr >> ADDR_LSB;
  assign w_ar_idx      = w_ar_sh[IDX_W-1:0];
  assign w_ar_in_range = ((w_ar_sh >> IDX_W) == '0) && ({1'b0, w_ar_idx} < NUM_REGS_L);

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_aw_addr <= s_axi.awaddr;
    if (w_w_hs) begin
      r_wdata <= s_axi.wdata;
      r_wstrb <= s_axi.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (w_aw_hs)      r_aw_full <= 1'b1;
      if (w_w_hs)       r_w_full  <= 1'b1;
      if (s_axi.bready) r_bvalid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else if (w_commit && w_wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wstrb[b]) r_regs[w_aw_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Reads sample r_regs before this edge's write lands, so a colliding read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      if (!w_ar_in_range) begin
        r_rresp <= RESP_SLVERR;
        r_rdata <= '0;
      end else begin
        r_rresp <= RESP_OKAY;
        r_rdata <= RO_MASK[w_ar_idx] ? w_reg_in[w_ar_idx] : r_regs[w_ar_idx];
      end
    end else if (s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end

`ifdef AXIL_REG_WR_PULSE_EN
  logic [NUM_REGS-1:0] r_wr_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_wr_ok) r_wr_pulse[w_aw_idx] <= 1'b1;
    end
  end

  assign wr_pulse = r_wr_pulse;
`else
  assign wr_pulse = '0;
`endif
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank: drivers push expected B/R responses from a
// register-array model; a negedge monitor pops and compares on every B/R handshake.
module tb_axi_lite_reg_bank;
  localparam int             DW      = 32;
  localparam int             AW      = 32;
  localparam int             NR      = 8;
  localparam logic [NR-1:0]  RO      = 8'h80;
  localparam logic [DW-1:0]  RST_VAL = 32'h0;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]    wr_pulse;

  axi_lite_reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_reg_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus), .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_done;
  logic [9:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [DW-1:0] model [NR];
  logic [NR-1:0] ro_mask = RO;
  bit          rand_ready = 1'b0;
  logic        b_hold = 1'b1;
  logic        r_hold = 1'b1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void flag(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected at t=%0t", name, $time);
  endfunction

  // Expected B entry: {bresp, one-hot of the register whose wr_pulse should fire}
  function automatic logic [9:0] model_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    int idx;
    if (addr >= 32'd32) return {2'b10, 8'h00};
    idx = int'(addr / 4);
    if (ro_mask[idx]) return {2'b10, 8'h00};
    for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    return {2'b00, 8'(1 << idx)};
  endfunction

  function automatic logic [33:0] model_read(logic [31:0] addr);
    int idx;
    if (addr >= 32'd32) return {2'b10, 32'h0};
    idx = int'(addr / 4);
    if (ro_mask[idx]) return {2'b00, reg_in[idx*DW +: DW]};
    return {2'b00, model[idx]};
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_aw(logic [31:0] a);
    bit done = 1'b0;
    int t = 0;
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk); done = bus.awready;
      @(posedge clk); #1; t++;
    end
    bus.awvalid = 1'b0;
    if (!done) flag("aw_handshake_timeout");
  endtask

  task automatic send_w(logic [31:0] d, logic [3:0] s);
    bit done = 1'b0;
    int t = 0;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk); done = bus.wready;
      @(posedge clk); #1; t++;
    end
    bus.wvalid = 1'b0;
    if (!done) flag("w_handshake_timeout");
  endtask

  task automatic send_ar(logic [31:0] a);
    bit done = 1'b0;
    int t = 0;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk); done = bus.arready;
      @(posedge clk); #1; t++;
    end
    bus.arvalid = 1'b0;
    if (!done) flag("ar_handshake_timeout");
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 300) begin
      tick(1);
      t++;
    end
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) flag("drain_timeout");
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] s, int dly_aw, int dly_w);
    exp_b_q.push_back(model_write(a, d, s));
    fork
      begin tick(dly_aw); send_aw(a); end
      begin tick(dly_w); send_w(d, s); end
    join
    if (!rand_ready && b_hold) check("b_latency", 64'(bus.bvalid), 64'd1);
    drain();
  endtask

  task automatic do_read(logic [31:0] a);
    exp_r_q.push_back(model_read(a));
    send_ar(a);
    drain();
  endtask

  // Response-ready driver: random back-pressure or values held by the main sequence.
  initial begin
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rand_ready) begin
        bus.bready = ($urandom_range(0, 3) != 0);
        bus.rready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.bready = b_hold;
        bus.rready = r_hold;
      end
    end
  end

  // Monitor: response checking, hold stability, ARREADY rule and wr_pulse timing.
  initial begin
    logic        pb_valid = 1'b0, pb_hs = 1'b0, pr_valid = 1'b0, pr_hs = 1'b0;
    logic [1:0]  pb_resp = 2'b0, pr_resp = 2'b0;
    logic [31:0] pr_data = 32'h0;
    logic [9:0]  eb;
    logic [33:0] er;
    logic [7:0]  p_exp;
    logic        new_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb_valid = 1'b0; pb_hs = 1'b0; pr_valid = 1'b0; pr_hs = 1'b0;
      end else begin
        new_b = bus.bvalid && (!pb_valid || pb_hs);
        p_exp = 8'h00;
`ifdef AXIL_REG_WR_PULSE_EN
        if (new_b && exp_b_q.size() != 0 && exp_b_q[0][9:8] == 2'b00) p_exp = exp_b_q[0][7:0];
`endif
        check("wr_pulse", 64'(wr_pulse), 64'(p_exp));
        if (pb_valid && !pb_hs) check("b_hold", {bus.bvalid, bus.bresp}, {1'b1, pb_resp});
        if (pr_valid && !pr_hs)
          check("r_hold", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, pr_resp, pr_data});
        check("arready_rule", 64'(bus.arready), 64'(!bus.rvalid || bus.rready));
        if (bus.bvalid && bus.bready) begin
          if (exp_b_q.size() == 0) flag("b_unexpected");
          else begin
            eb = exp_b_q.pop_front();
            check("bresp", 64'(bus.bresp), 64'(eb[9:8]));
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r_q.size() == 0) flag("r_unexpected");
          else begin
            er = exp_r_q.pop_front();
            check("rresp_rdata", {bus.rresp, bus.rdata}, 64'(er));
          end
        end
        pb_valid = bus.bvalid; pb_hs = bus.bvalid && bus.bready; pb_resp = bus.bresp;
        pr_valid = bus.rvalid; pr_hs = bus.rvalid && bus.rready;
        pr_resp = bus.rresp;   pr_data = bus.rdata;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d, old3;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    for (int i = 0; i < NR - 1; i++) reg_in[i*DW +: DW] = $urandom();
    reg_in[7*DW +: DW] = 32'hCAFE0001;
    for (int i = 0; i < NR; i++) model[i] = RST_VAL;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 64'd0);
    for (int i = 0; i < NR; i++) do_read(32'(i * 4));

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 3, 0);
    do_read(32'h4);
    check("reg_out_1", 64'(reg_out[63:32]), 64'hDEADBEEF);

    do_write(32'h8, 32'h11223344, 4'hF, 0, 0);
    do_write(32'h8, 32'hAABBCCDD, 4'b0101, 1, 0);
    do_read(32'h8);
    check("lane_merge", 64'(reg_out[95:64]), 64'h11BB33DD);

    do_write(32'h1C, 32'h55555555, 4'hF, 0, 2);
    do_read(32'h1C);
    do_read(32'h20);
    do_read(32'h8000_0004);
    do_write(32'h24, 32'h12345678, 4'hF, 0, 0);
    do_write(32'h4, 32'h12345678, 4'h0, 0, 1);
    do_read(32'h7);

    // Read and write to reg 3 on the same edge: read must see the old value.
    exp_r_q.push_back(model_read(32'hC));
    exp_b_q.push_back(model_write(32'hC, 32'h5A5A0F0F, 4'hF));
    fork
      send_aw(32'hC);
      send_w(32'h5A5A0F0F, 4'hF);
      send_ar(32'hC);
    join
    drain();

    for (int k = 0; k < 4; k++) begin
      d = $urandom();
      exp_b_q.push_back(model_write(32'(k * 4 + 16), d, 4'hF));
      bus.awaddr = 32'(k * 4 + 16); bus.wdata = d; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      @(negedge clk);
      check("b2b_aw_w_ready", {bus.awready, bus.wready}, 64'd3);
      tick(1);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    drain();
    for (int k = 0; k < NR; k++) begin
      exp_r_q.push_back(model_read(32'(k * 4)));
      bus.araddr = 32'(k * 4); bus.arvalid = 1'b1;
      @(negedge clk);
      check("b2b_arready", 64'(bus.arready), 64'd1);
      tick(1);
    end
    bus.arvalid = 1'b0;
    drain();

    // Back-pressure: one B and one R held, a second write and a read left pending.
    b_hold = 1'b0; r_hold = 1'b0;
    d = $urandom();
    exp_b_q.push_back(model_write(32'h14, d, 4'hF));
    fork send_aw(32'h14); send_w(d, 4'hF); join
    exp_r_q.push_back(model_read(32'h14));
    send_ar(32'h14);
    old3 = model[3];
    d = $urandom();
    exp_b_q.push_back(model_write(32'hC, d, 4'hF));
    exp_b_q.push_back(model_write(32'h40, 32'hFFFFFFFF, 4'hF));
    exp_r_q.push_back(model_read(32'h18));
    n_done = 0;
    fork
      begin send_aw(32'hC); send_aw(32'h40); n_done++; end
      begin send_w(d, 4'hF); send_w(32'hFFFFFFFF, 4'hF); n_done++; end
      begin send_ar(32'h18); n_done++; end
    join_none
    tick(5);
    check("stall_awready", 64'(bus.awready), 64'd0);
    check("stall_wready", 64'(bus.wready), 64'd0);
    check("stall_arready", 64'(bus.arready), 64'd0);
    check("stall_valids", {bus.bvalid, bus.rvalid}, 64'd3);
    check("stall_no_commit", 64'(reg_out[3*DW +: DW]), 64'(old3));
    b_hold = 1'b1; r_hold = 1'b1;
    tick(1);
    check("bready_commit", 64'(reg_out[3*DW +: DW]), 64'(model[3]));
    for (int t = 0; t < 100 && n_done < 3; t++) tick(1);
    if (n_done < 3) flag("stall_threads");
    drain();

    // Reset with an AW captured but no W yet.
    send_aw(32'h0);
    rst = 1'b1;
    exp_b_q.delete();
    exp_r_q.delete();
    for (int i = 0; i < NR; i++) model[i] = RST_VAL;
    tick(1);
    rst = 1'b0;
    check("rst2_valids", {bus.bvalid, bus.rvalid}, 64'd0);
    check("rst2_ready", {bus.awready, bus.wready, bus.arready}, 64'd7);
    send_w(32'h0BADF00D, 4'hF);
    tick(3);
    check("no_stale_commit", 64'(bus.bvalid), 64'd0);
    check("w_slot_held", {bus.awready, bus.wready}, 64'd2);
    check("rst2_reg0", 64'(reg_out[31:0]), 64'(RST_VAL));
    exp_b_q.push_back(model_write(32'h0, 32'h0BADF00D, 4'hF));
    send_aw(32'h0);
    drain();
    do_read(32'h0);
    do_read(32'h4);

    rand_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(5, 31));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a);
    end
    rand_ready = 1'b0;
    tick(2);
    for (int i = 0; i < NR; i++) begin
      if (!ro_mask[i]) check("final_reg_out", 64'(reg_out[i*DW +: DW]), 64'(model[i]));
    end
    check("queues_empty", 64'(exp_b_q.size() + exp_r_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
